// File: rtl/led_mmio_if.sv
// led_mmio_if: store/load bus between the core and the LED/switch peripheral
interface led_mmio_if;
    logic        ledWriteEnable;
    logic        readEnable;
    logic [1:0]  addrOffset;
    logic [31:0] writeData;
    logic [31:0] readData;
    modport master(output ledWriteEnable, readEnable, addrOffset, writeData, input readData);
    modport slave(input ledWriteEnable, readEnable, addrOffset, writeData, output readData);
endinterface

// File: rtl/led_mmio_peripheral.sv
// led_mmio_peripheral: memory-mapped LEDs with hardware blink, debounced switches and sticky change flag
module led_mmio_peripheral #(
    parameter int LED_WIDTH = 16,
    parameter int SW_WIDTH = 16,
    parameter int BLINK_DIV = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    led_mmio_if.slave            bus,
    input  logic [SW_WIDTH-1:0]  switches,
    output logic [LED_WIDTH-1:0] leds
);
    localparam int BW = $clog2(BLINK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    logic [LED_WIDTH-1:0] ledValue, blinkMask;
    logic [BW-1:0] blinkCnt;
    logic blinkPhase, swChanged;
    logic [SW_WIDTH-1:0] syncA, swSync, swCandidate, swStable;
    logic [DW-1:0] dbCnt;
    logic wrLed, wrMask, wrClr, commit;
    assign wrLed = bus.ledWriteEnable && bus.addrOffset == 2'd0;
    assign wrMask = bus.ledWriteEnable && bus.addrOffset == 2'd1;
    assign wrClr = bus.ledWriteEnable && bus.addrOffset == 2'd3 && bus.writeData[1];
    assign commit = swSync == swCandidate && dbCnt == DB_LAST && swCandidate != swStable;
    always_ff @(posedge clk) begin
        if (rst) begin
            ledValue <= '0;
            blinkMask <= '0;
        end else begin
            if (wrLed) ledValue <= bus.writeData[LED_WIDTH-1:0];
            if (wrMask) blinkMask <= bus.writeData[LED_WIDTH-1:0];
        end
    end
    // A new mask restarts the blink cycle so all newly blinking LEDs start lit
    always_ff @(posedge clk) begin
        if (rst || wrMask) begin
            blinkCnt <= '0;
            blinkPhase <= 1'b0;
        end else if (blinkCnt == BLINK_LAST) begin
            blinkCnt <= '0;
            blinkPhase <= ~blinkPhase;
        end else begin
            blinkCnt <= blinkCnt + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            syncA <= '0;
            swSync <= '0;
        end else begin
            syncA <= switches;
            swSync <= syncA;
        end
    end
    // Counter saturates at DB_LAST so a settled input never re-triggers
    always_ff @(posedge clk) begin
        if (rst) begin
            swCandidate <= '0;
            swStable <= '0;
            dbCnt <= '0;
        end else if (swSync != swCandidate) begin
            swCandidate <= swSync;
            dbCnt <= '0;
        end else if (commit) begin
            swStable <= swCandidate;
        end else if (dbCnt != DB_LAST) begin
            dbCnt <= dbCnt + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) swChanged <= 1'b0;
        else if (commit) swChanged <= 1'b1;
        else if (wrClr) swChanged <= 1'b0;
    end
    assign leds = ledValue & ~(blinkMask & {LED_WIDTH{blinkPhase}});
    always_comb begin
        bus.readData = !bus.readEnable ? 32'h0 :
                       bus.addrOffset == 2'd0 ? 32'(ledValue) :
                       bus.addrOffset == 2'd1 ? 32'(blinkMask) :
                       bus.addrOffset == 2'd2 ? 32'(swStable) :
                       {30'b0, swChanged, blinkPhase};
    end
endmodule

// File: tb/tb_led_mmio_peripheral.sv
// tb_led_mmio_peripheral: directed scenarios plus randomized traffic against a cycle-count reference model
module tb_led_mmio_peripheral;
    localparam int BD = 4;
    localparam int DC = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] switches = '0;
    logic [15:0] leds;
    int checks = 0;
    int passed = 0;
    led_mmio_if bus();
    led_mmio_peripheral #(.LED_WIDTH(16), .SW_WIDTH(16), .BLINK_DIV(BD), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .bus(bus), .switches(switches), .leds(leds)
    );
    always #10 clk = ~clk;
    logic [15:0] mLed, mMask, mStable, d0, d1;
    logic mChanged;
    int mCyc;
    logic [15:0] hist[$];
    function automatic logic mPhase();
        return ((mCyc / BD) % 2) == 1;
    endfunction
    function automatic logic [15:0] expLeds();
        return mLed & ~(mMask & {16{mPhase()}});
    endfunction
    function automatic logic [31:0] expRead(input logic [1:0] a);
        case (a)
            2'd0: return {16'h0, mLed};
            2'd1: return {16'h0, mMask};
            2'd2: return {16'h0, mStable};
            default: return {30'h0, mChanged, mPhase()};
        endcase
    endfunction
    // Switch value commits once the synchronized input has been seen unchanged on DC+1 consecutive edges
    task automatic modelEdge();
        logic [15:0] s;
        bit same;
        if (rst) begin
            mLed = 0; mMask = 0; mStable = 0; mChanged = 0; mCyc = 0; d0 = 0; d1 = 0;
            hist.delete();
        end else begin
            s = d1; d1 = d0; d0 = switches;
            hist.push_back(s);
            if (hist.size() > DC + 1) void'(hist.pop_front());
            same = hist.size() == DC + 1;
            foreach (hist[i]) if (hist[i] !== s) same = 0;
            if (same && s != mStable) begin
                mStable = s;
                mChanged = 1;
            end else if (bus.ledWriteEnable && bus.addrOffset == 2'd3 && bus.writeData[1]) begin
                mChanged = 0;
            end
            if (bus.ledWriteEnable && bus.addrOffset == 2'd0) mLed = bus.writeData[15:0];
            if (bus.ledWriteEnable && bus.addrOffset == 2'd1) begin
                mMask = bus.writeData[15:0];
                mCyc = 0;
            end else begin
                mCyc++;
            end
        end
    endtask
    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask
    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus.readEnable = 1'b1;
        bus.addrOffset = a;
        #1;
        v = bus.readData;
        bus.readEnable = 1'b0;
    endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.ledWriteEnable = 1'b1;
        bus.addrOffset = a;
        bus.writeData = d;
        tick();
        bus.ledWriteEnable = 1'b0;
    endtask
    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (leds !== 16'h0) $display("FAIL reset_leds: got %h want 0000", leds); else passed++;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            checks++; if (v !== 32'h0) $display("FAIL reset_read%0d: got %h want 00000000", a, v); else passed++;
        end
    endtask
    task automatic test_led_write();
        logic [31:0] v;
        wr(2'd0, 32'hFFFF_00A5);
        checks++; if (leds !== 16'h00A5) $display("FAIL led_write_leds: got %h want 00a5", leds); else passed++;
        rd(2'd0, v);
        checks++; if (v !== 32'h0000_00A5) $display("FAIL led_write_read: got %h want 000000a5", v); else passed++;
        bus.readEnable = 1'b0;
        bus.addrOffset = 2'd0;
        #1;
        checks++; if (bus.readData !== 32'h0) $display("FAIL read_disabled: got %h want 00000000", bus.readData); else passed++;
    endtask
    task automatic test_blink();
        logic [31:0] v;
        logic ph;
        wr(2'd0, 32'h00FF);
        wr(2'd1, 32'h000F);
        for (int k = 0; k < 16; k++) begin
            ph = ((k / 4) % 2) == 1;
            checks++; if (leds !== (ph ? 16'h00F0 : 16'h00FF)) $display("FAIL blink_leds k=%0d: got %h want %h", k, leds, ph ? 16'h00F0 : 16'h00FF); else passed++;
            rd(2'd3, v);
            checks++; if (v[0] !== ph) $display("FAIL blink_phase k=%0d: got %b want %b", k, v[0], ph); else passed++;
            tick();
        end
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h0);
    endtask
    task automatic test_glitch();
        logic [31:0] v;
        switches = 16'h0001;
        tick();
        tick();
        switches = 16'h0000;
        repeat (10) tick();
        rd(2'd2, v);
        checks++; if (v !== 32'h0) $display("FAIL glitch_switches: got %h want 00000000", v); else passed++;
        rd(2'd3, v);
        checks++; if (v[1] !== 1'b0) $display("FAIL glitch_changed: got %b want 0", v[1]); else passed++;
    endtask
    task automatic test_latency();
        logic [31:0] v;
        switches = 16'h1234;
        tick();
        tick();
        tick();
        wr(2'd1, 32'h0);
        tick();
        rd(2'd2, v);
        checks++; if (v !== 32'h0) $display("FAIL latency_early: got %h want 00000000", v); else passed++;
        tick();
        rd(2'd2, v);
        checks++; if (v !== 32'h0000_1234) $display("FAIL latency_switches: got %h want 00001234", v); else passed++;
        rd(2'd3, v);
        checks++; if (v !== 32'h2) $display("FAIL latency_status: got %h want 00000002", v); else passed++;
    endtask
    task automatic test_w1c();
        logic [31:0] v;
        wr(2'd3, 32'h2);
        rd(2'd3, v);
        checks++; if (v[1] !== 1'b0) $display("FAIL w1c_clear: got %b want 0", v[1]); else passed++;
        switches = 16'h00FF;
        repeat (5) tick();
        wr(2'd3, 32'h2);
        rd(2'd3, v);
        checks++; if (v[1] !== 1'b1) $display("FAIL w1c_set_wins: got %b want 1", v[1]); else passed++;
        rd(2'd2, v);
        checks++; if (v !== 32'h0000_00FF) $display("FAIL w1c_switches: got %h want 000000ff", v); else passed++;
        wr(2'd3, 32'h1);
        rd(2'd3, v);
        checks++; if (v[1] !== 1'b1) $display("FAIL w1c_bit0_ignored: got %b want 1", v[1]); else passed++;
        wr(2'd3, 32'h2);
        rd(2'd3, v);
        checks++; if (v[1] !== 1'b0) $display("FAIL w1c_cleared: got %b want 0", v[1]); else passed++;
        wr(2'd0, 32'h5A5A);
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, v);
        checks++; if (v !== 32'h0000_00FF) $display("FAIL ro_switches: got %h want 000000ff", v); else passed++;
        rd(2'd0, v);
        checks++; if (v !== 32'h0000_5A5A) $display("FAIL ro_led_value: got %h want 00005a5a", v); else passed++;
        checks++; if (leds !== 16'h5A5A) $display("FAIL ro_leds: got %h want 5a5a", leds); else passed++;
    endtask
    task automatic test_read_during_write();
        bus.ledWriteEnable = 1'b1;
        bus.addrOffset = 2'd0;
        bus.writeData = 32'hABCD_1357;
        bus.readEnable = 1'b1;
        #1;
        checks++; if (bus.readData !== 32'h0000_5A5A) $display("FAIL rdw_old: got %h want 00005a5a", bus.readData); else passed++;
        tick();
        bus.ledWriteEnable = 1'b0;
        #1;
        checks++; if (bus.readData !== 32'h0000_1357) $display("FAIL rdw_new: got %h want 00001357", bus.readData); else passed++;
        bus.readEnable = 1'b0;
    endtask
    task automatic test_random();
        logic [31:0] want;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom % 150) == 0;
            bus.ledWriteEnable = ($urandom % 3) == 0;
            bus.addrOffset = 2'($urandom);
            bus.writeData = $urandom;
            bus.readEnable = $urandom % 2;
            if (($urandom % 8) == 0) switches = 16'($urandom);
            #1;
            want = bus.readEnable ? expRead(bus.addrOffset) : 32'h0;
            checks++; if (bus.readData !== want) $display("FAIL rand_read i=%0d off=%0d: got %h want %h", i, bus.addrOffset, bus.readData, want); else passed++;
            checks++; if (leds !== expLeds()) $display("FAIL rand_leds i=%0d: got %h want %h", i, leds, expLeds()); else passed++;
            tick();
        end
        rst = 1'b0;
        bus.ledWriteEnable = 1'b0;
        bus.readEnable = 1'b0;
    endtask
    initial begin
        bus.ledWriteEnable = 1'b0;
        bus.readEnable = 1'b0;
        bus.addrOffset = 2'd0;
        bus.writeData = 32'h0;
        test_reset();
        test_led_write();
        test_blink();
        test_glitch();
        test_latency();
        test_w1c();
        test_read_during_write();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
